// File: rtl/ram_access_ctrl.sv
// Load/store sequencer between the core and a synchronous data RAM; every output is registered.
// Optional RAM_INIT_CLEAR_EN: zero-fill the whole RAM after reset before accepting requests.
module ram_access_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_ack,
  output logic [DW-1:0] core_rdata,
  output logic          busy,
  output logic          ram_cs,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  // state      | meaning
  // IDLE       | waiting for core_req; latches address and store data on acceptance
  // RD_ISSUE   | cs+rd strobe cycle
  // RD_WAIT    | RAM output settles; captured into core_rdata at the end of this cycle
  // RD_CAP     | load ack cycle
  // WR_ISSUE   | cs+wr strobe cycle
  // WR_ACK     | store ack cycle
  // DONE       | dead cycle so the core can drop core_req after ack
  // CLEAR      | zero-fill sweep after reset (RAM_INIT_CLEAR_EN only)
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_CAP,
    S_WR_ISSUE,
    S_WR_ACK,
    S_DONE
`ifdef RAM_INIT_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

`ifdef RAM_INIT_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t        r_state;
  state_t        w_next;

  logic          r_ack;
  logic [DW-1:0] r_rdata;
  logic          r_busy;
  logic          r_cs;
  logic          r_rd;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          w_ack_d;
  logic [DW-1:0] w_rdata_d;
  logic          w_busy_d;
  logic          w_cs_d;
  logic          w_rd_d;
  logic          w_wr_d;
  logic [AW-1:0] w_addr_d;
  logic [DW-1:0] w_wdata_d;

`ifdef RAM_INIT_CLEAR_EN
  logic [AW-1:0] r_clr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_clr_cnt <= '0;
    else if (r_state == S_CLEAR)
      r_clr_cnt <= r_clr_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= RST_STATE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (core_req) w_next = core_we ? S_WR_ISSUE : S_RD_ISSUE;
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT:  w_next = S_RD_CAP;
      S_RD_CAP:   w_next = S_DONE;
      S_WR_ISSUE: w_next = S_WR_ACK;
      S_WR_ACK:   w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
`ifdef RAM_INIT_CLEAR_EN
      // the last sweep write goes out during DONE, so busy stays high for it
      S_CLEAR:    if (r_clr_cnt == {AW{1'b1}}) w_next = S_DONE;
`endif
      default:    w_next = S_IDLE;
    endcase
  end

  // registered outputs are decoded from the state being entered
  always_comb begin
    w_rd_d    = (w_next == S_RD_ISSUE);
    w_wr_d    = (w_next == S_WR_ISSUE);
    w_ack_d   = (w_next == S_RD_CAP) || (w_next == S_WR_ACK);
    w_busy_d  = (w_next != S_IDLE);
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_rdata_d = r_rdata;
    if (r_state == S_IDLE && core_req) begin
      w_addr_d  = core_addr;
      w_wdata_d = core_wdata;
    end
    if (r_state == S_RD_WAIT)
      w_rdata_d = ram_rdata;
`ifdef RAM_INIT_CLEAR_EN
    if (r_state == S_CLEAR) begin
      w_wr_d    = 1'b1;
      w_addr_d  = r_clr_cnt;
      w_wdata_d = '0;
    end
`endif
    w_cs_d = w_rd_d | w_wr_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_cs    <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_ack   <= w_ack_d;
      r_rdata <= w_rdata_d;
      r_busy  <= w_busy_d;
      r_cs    <= w_cs_d;
      r_rd    <= w_rd_d;
      r_wr    <= w_wr_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
    end
  end

  assign core_ack   = r_ack;
  assign core_rdata = r_rdata;
  assign busy       = r_busy;
  assign ram_cs     = r_cs;
  assign ram_rd     = r_rd;
  assign ram_wr     = r_wr;
  assign ram_addr   = r_addr;
  assign ram_wdata  = r_wdata;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: directed table, held-request and mid-read reset sequences, random traffic.
// A synchronous RAM model sits on the RAM port; expected data comes from a word-array memory model.
module tb_ram_access_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef RAM_INIT_CLEAR_EN
  localparam logic [7:0] INIT_VAL = 8'h00;
`else
  localparam logic [7:0] INIT_VAL = 8'hC3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_ack;
  logic [DW-1:0] core_rdata;
  logic          busy;
  logic          ram_cs;
  logic          ram_rd;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  logic [7:0] mem     [256] = '{default: 8'hC3};
  logic [7:0] ref_mem [256] = '{default: 8'hC3};
  logic [7:0] last_rd = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  ram_access_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata), .busy(busy),
    .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_cs && ram_rd) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_wr_exclusive", {31'd0, ram_rd & ram_wr}, 32'd0);
      chk("cs_iff_strobe", {31'd0, ram_cs}, {31'd0, ram_rd | ram_wr});
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 600 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic access(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input int exp_lat, input string nm);
    bit got = 0;
    int lat = 0;
    int ncs = 0;
    wait_idle();
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(posedge clk); #1;
      if (ram_cs) begin
        ncs++;
        chk({nm, "_addr"}, {24'd0, ram_addr}, {24'd0, a});
        chk({nm, "_wr"}, {31'd0, ram_wr}, {31'd0, we});
        if (we) chk({nm, "_wdata"}, {24'd0, ram_wdata}, {24'd0, d});
      end
      if (core_ack) begin
        got = 1; lat = k; core_req = 1'b0;
        chk({nm, "_rdata"}, {24'd0, core_rdata}, {24'd0, exp_rd});
      end
    end
    core_req = 1'b0;
    chk({nm, "_ack_seen"}, {31'd0, got}, 32'd1);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_strobes"}, ncs, 1);
    if (we) ref_mem[a] = d;
    else    last_rd = exp_rd;
  endtask

`ifdef RAM_INIT_CLEAR_EN
  task automatic clear_check(input bit hold);
    int idx = 0;
    bit got = 0;
    if (hold) begin
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h80;
    end
    for (int c = 0; c < 300 && idx < 256; c++) begin
      @(posedge clk); #1;
      if (core_ack) chk("clear_no_ack", 32'd1, 32'd0);
      if (ram_cs) begin
        chk("clear_addr", {24'd0, ram_addr}, idx);
        chk("clear_data", {24'd0, ram_wdata}, 32'd0);
        chk("clear_busy", {31'd0, busy}, 32'd1);
        idx++;
      end
    end
    chk("clear_count", idx, 256);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    if (hold) begin
      for (int c = 0; c < 10 && !got; c++) begin
        @(posedge clk); #1;
        if (core_ack) begin
          got = 1; core_req = 1'b0;
          chk("clear_req_rdata", {24'd0, core_rdata}, 32'd0);
        end
      end
      core_req = 1'b0;
      chk("clear_req_acked", {31'd0, got}, 32'd1);
      last_rd = 8'h00;
    end
  endtask
`endif

  task automatic do_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h80; rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ack",   {31'd0, core_ack}, 32'd0);
    chk("rst_rdata", {24'd0, core_rdata}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_cs",    {31'd0, ram_cs}, 32'd0);
    chk("rst_rd",    {31'd0, ram_rd}, 32'd0);
    chk("rst_wr",    {31'd0, ram_wr}, 32'd0);
    chk("rst_addr",  {24'd0, ram_addr}, 32'd0);
    chk("rst_wdata", {24'd0, ram_wdata}, 32'd0);
    last_rd = 8'h00;
    rst_n = 1'b1; core_req = 1'b0;
`ifdef RAM_INIT_CLEAR_EN
    clear_check(1'b0);
`endif
  endtask

  task automatic held(input logic we, input logic [7:0] a0, input logic [7:0] d0, input int sp);
    int acks = 0;
    int t_last = 0;
    int ncs = 0;
    logic [7:0] a = a0;
    logic [7:0] d = d0;
    wait_idle();
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ram_cs) begin
        ncs++;
        chk("held_addr", {24'd0, ram_addr}, {24'd0, a});
      end
      if (core_ack) begin
        acks++;
        if (acks > 1) chk("held_spacing", c - t_last, sp);
        t_last = c;
        if (we) ref_mem[a] = d;
        else begin
          chk("held_rdata", {24'd0, core_rdata}, {24'd0, ref_mem[a]});
          last_rd = ref_mem[a];
        end
        if (acks >= 3) core_req = 1'b0;
        else begin
          a = a + 8'd1; d = d + 8'd1;
          core_addr = a; core_wdata = d;
        end
      end
    end
    core_req = 1'b0;
    chk("held_acks", acks, 3);
    chk("held_strobes", ncs, 3);
  endtask

  task automatic mid_read_reset(input logic [7:0] a);
    int acks = 0;
    wait_idle();
    core_req = 1'b1; core_we = 1'b0; core_addr = a;
    @(posedge clk); #1;
    chk("mr_issue", {30'd0, ram_cs, ram_rd}, 32'd3);
    core_req = 1'b0;
    @(posedge clk); #1;
    chk("mr_wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mr_ack",   {31'd0, core_ack}, 32'd0);
    chk("mr_cs",    {31'd0, ram_cs}, 32'd0);
    chk("mr_rd",    {31'd0, ram_rd}, 32'd0);
    chk("mr_rdata", {24'd0, core_rdata}, 32'd0);
    chk("mr_busy",  {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    last_rd = 8'h00;
`ifdef RAM_INIT_CLEAR_EN
    clear_check(1'b0);
`else
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (core_ack) acks++;
    end
    chk("mr_no_ack", acks, 0);
`endif
    access(1'b0, a, 8'h00, ref_mem[a], 3, "mr_load");
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic       rwe;
    logic [7:0] ra, rd, rex;

    tbl[0] = '{1'b1, 8'h05, 8'hA5, 8'h00,    2};
    tbl[1] = '{1'b0, 8'h05, 8'h00, 8'hA5,    3};
    tbl[2] = '{1'b1, 8'hFF, 8'h3C, 8'hA5,    2};
    tbl[3] = '{1'b1, 8'h00, 8'h11, 8'hA5,    2};
    tbl[4] = '{1'b0, 8'hFF, 8'h00, 8'h3C,    3};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h11,    3};
    tbl[6] = '{1'b1, 8'h05, 8'h5A, 8'h11,    2};
    tbl[7] = '{1'b0, 8'h05, 8'h00, 8'h5A,    3};
    tbl[8] = '{1'b0, 8'h42, 8'h00, INIT_VAL, 3};

    do_reset();

    for (int i = 0; i < 9; i++)
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_lat, "tbl");

    held(1'b1, 8'h01, 8'h71, 4);
    held(1'b0, 8'h01, 8'h00, 5);

    mid_read_reset(8'hFF);

    for (int i = 0; i < 80; i++) begin
      rwe = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 255));
      rd  = 8'($urandom_range(0, 255));
      rex = rwe ? last_rd : ref_mem[ra];
      access(rwe, ra, rd, rex, rwe ? 2 : 3, "rand");
    end

`ifdef RAM_INIT_CLEAR_EN
    wait_idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_rd = 8'h00;
    clear_check(1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
